memaccess_lsu: RTL and testbench

- Memory-access stage load/store unit. Consumes the MA-side outputs of the execute stage: ma_inst, ma_pc, ma_dat (address or ALU result) and ma_rd2 (store data).
- Drives a req/gnt/rvalid data-memory bus and produces registered writeback-stage outputs.
- Asserts ma_stall so upstream stages hold while a memory transaction is outstanding.
- Sits between execute_top and the writeback stage.

---
 rtl/memaccess_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_memaccess_lsu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memaccess_lsu.sv
// memaccess_lsu: memory-access stage load/store unit.
// Issues loads/stores from the MA-stage instruction onto a req/gnt/rvalid
// data-memory bus, stalls upstream while a transaction is outstanding and
// registers the writeback-stage outputs.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   ma_inst/ma_pc/ma_dat/ma_rd2   MA-stage instruction, PC, ALU result/address, store data
//   ma_stall                      combinational upstream hold
//   dmem_req/we/addr/be/wdat      memory request channel (combinational in IDLE, captured otherwise)
//   dmem_gnt/rvalid/rdat          memory grant and read-response channel
//   wb_inst/wb_pc/wb_dat          registered writeback outputs
//   wb_misalign                   one-cycle misaligned-access flag
//
// Optional feature: define ETCPU_MA_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses instead of issuing them.
module memaccess_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ma_inst,
  input  logic [31:0] ma_pc,
  input  logic [31:0] ma_dat,
  input  logic [31:0] ma_rd2,
  output logic        ma_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdat,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdat,
  output logic [31:0] wb_inst,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_dat,
  output logic        wb_misalign
);

  localparam int unsigned XLEN = 32;
  localparam logic [6:0]      OP_LOAD  = 7'b0000011;
  localparam logic [6:0]      OP_STORE = 7'b0100011;
  localparam logic [XLEN-1:0] BUBBLE   = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

  state_t          state;
  logic [XLEN-1:0] cap_inst, cap_pc, cap_dat, cap_wdat;
  logic [3:0]      cap_be;
  logic            cap_we;
  logic [2:0]      cap_f3;

  logic [2:0]      funct3_c;
  logic            is_load_c, is_store_c, mem_op_c, misalign_c, issue_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdat_c, ld_ext_c;
  logic [7:0]      ld_byte_c;
  logic [15:0]     ld_half_c;

  // Decode of the incoming MA-stage instruction
  assign funct3_c   = ma_inst[14:12];
  assign is_load_c  = (ma_inst[6:0] == OP_LOAD);
  assign is_store_c = (ma_inst[6:0] == OP_STORE);
  assign mem_op_c   = is_load_c | is_store_c;
  assign issue_c    = mem_op_c & ~misalign_c;

  // Byte enables and lane-replicated write data; funct3[1:0] gives access size
  always_comb begin
    be_c   = 4'hF;
    wdat_c = ma_rd2;
    case (funct3_c[1:0])
      2'b00: begin
        be_c   = 4'b0001 << ma_dat[1:0];
        wdat_c = {4{ma_rd2[7:0]}};
      end
      2'b01: begin
        be_c   = 4'b0011 << {ma_dat[1], 1'b0};
        wdat_c = {2{ma_rd2[15:0]}};
      end
      default: begin
        be_c   = 4'hF;
        wdat_c = ma_rd2;
      end
    endcase
  end

`ifdef ETCPU_MA_MISALIGN_TRAP_EN
  // Halfword needs a[0]==0, word needs a[1:0]==0; funct3 3/6/7 count as word
  always_comb begin
    misalign_c = 1'b0;
    if (mem_op_c) begin
      case (funct3_c[1:0])
        2'b00:   misalign_c = 1'b0;
        2'b01:   misalign_c = ma_dat[0];
        default: misalign_c = |ma_dat[1:0];
      endcase
    end
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Bus outputs and stall: live from ma_* in IDLE, from captured copies afterwards
  always_comb begin
    dmem_req  = 1'b0;
    dmem_we   = cap_we;
    dmem_addr = {cap_dat[31:2], 2'b00};
    dmem_be   = cap_be;
    dmem_wdat = cap_wdat;
    ma_stall  = 1'b0;
    case (state)
      IDLE: begin
        dmem_req  = issue_c;
        dmem_we   = is_store_c;
        dmem_addr = {ma_dat[31:2], 2'b00};
        dmem_be   = be_c;
        dmem_wdat = wdat_c;
        ma_stall  = issue_c & ~(is_store_c & dmem_gnt);
      end
      REQ: begin
        dmem_req = 1'b1;
        ma_stall = ~(cap_we & dmem_gnt);
      end
      WAIT_RD: begin
        ma_stall = ~dmem_rvalid;
      end
      default: begin
        dmem_req = 1'b0;
        ma_stall = 1'b0;
      end
    endcase
  end

  // Load lane select and extension from the captured address/funct3
  assign ld_byte_c = 8'(dmem_rdat >> {cap_dat[1:0], 3'b000});
  assign ld_half_c = 16'(dmem_rdat >> {cap_dat[1], 4'b0000});

  always_comb begin
    case (cap_f3)
      3'd0:    ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'd4:    ld_ext_c = {24'd0, ld_byte_c};
      3'd1:    ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'd5:    ld_ext_c = {16'd0, ld_half_c};
      default: ld_ext_c = dmem_rdat;
    endcase
  end

  // FSM, capture registers and writeback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap_inst    <= BUBBLE;
      cap_pc      <= '0;
      cap_dat     <= '0;
      cap_wdat    <= '0;
      cap_be      <= '0;
      cap_we      <= 1'b0;
      cap_f3      <= '0;
      wb_inst     <= BUBBLE;
      wb_pc       <= '0;
      wb_dat      <= '0;
      wb_misalign <= 1'b0;
    end else begin
      wb_misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_c) begin
            cap_inst <= ma_inst;
            cap_pc   <= ma_pc;
            cap_dat  <= ma_dat;
            cap_wdat <= wdat_c;
            cap_be   <= be_c;
            cap_we   <= is_store_c;
            cap_f3   <= funct3_c;
            if (is_store_c && dmem_gnt) begin
              wb_inst <= ma_inst;
              wb_pc   <= ma_pc;
              wb_dat  <= ma_dat;
            end else begin
              wb_inst <= BUBBLE;
              state   <= (is_load_c && dmem_gnt) ? WAIT_RD : REQ;
            end
          end else if (misalign_c) begin
            wb_inst     <= BUBBLE;
            wb_pc       <= ma_pc;
            wb_dat      <= ma_dat;
            wb_misalign <= 1'b1;
          end else begin
            wb_inst <= ma_inst;
            wb_pc   <= ma_pc;
            wb_dat  <= ma_dat;
          end
        end
        REQ: begin
          if (dmem_gnt && cap_we) begin
            wb_inst <= cap_inst;
            wb_pc   <= cap_pc;
            wb_dat  <= cap_dat;
            state   <= IDLE;
          end else begin
            wb_inst <= BUBBLE;
            if (dmem_gnt) state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (dmem_rvalid) begin
            wb_inst <= cap_inst;
            wb_pc   <= cap_pc;
            wb_dat  <= ld_ext_c;
            state   <= IDLE;
          end else begin
            wb_inst <= BUBBLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memaccess_lsu.sv
// Bench for memaccess_lsu: directed vector table, reset-in-flight sequence
// and randomized transactions checked against a transaction-level model.
module tb_memaccess_lsu;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ma_inst, ma_pc, ma_dat, ma_rd2;
  logic        ma_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdat;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdat;
  logic [31:0] wb_inst, wb_pc, wb_dat;
  logic        wb_misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memaccess_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ma_inst(ma_inst), .ma_pc(ma_pc), .ma_dat(ma_dat), .ma_rd2(ma_rd2),
    .ma_stall(ma_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdat(dmem_wdat),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdat(dmem_rdat),
    .wb_inst(wb_inst), .wb_pc(wb_pc), .wb_dat(wb_dat), .wb_misalign(wb_misalign)
  );

  typedef struct {
    logic [31:0] inst, pc, dat, rd2, rdat;
    int          gnt_dly, rv_dly;
    logic [31:0] exp_dat, exp_addr, exp_wdat;
    logic [3:0]  exp_be;
    int          exp_stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ld(input logic [2:0] f3);
    return {17'h0, f3, 5'd5, 7'h03};
  endfunction

  function automatic logic [31:0] st(input logic [2:0] f3);
    return {7'h0, 5'd2, 5'd1, f3, 5'd0, 7'h23};
  endfunction

  // Reference model: plain arithmetic on addresses and lanes
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned v;
    if (f3 == 3'd0)      v = 1 << (a % 4);
    else if (f3 == 3'd1) v = 3 << (2 * ((a / 2) % 2));
    else                 v = 15;
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdat(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef ETCPU_MA_MISALIGN_TRAP_EN
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) != 0;
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic vec_t tv(input logic [31:0] inst, pc, dat, rd2, input int gd, rd,
                              input logic [31:0] rdat, exp_dat, exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdat,
                              input int exp_stall);
    vec_t v;
    v.inst = inst; v.pc = pc; v.dat = dat; v.rd2 = rd2; v.rdat = rdat;
    v.gnt_dly = gd; v.rv_dly = rd;
    v.exp_dat = exp_dat; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdat = exp_wdat; v.exp_stall = exp_stall;
    return v;
  endfunction

  function automatic vec_t model_vec(input logic [31:0] inst, pc, dat, rd2, input int gd, rd,
                                     input logic [31:0] rdat);
    logic [2:0] f3;
    bit ldop, stop;
    vec_t v;
    f3   = inst[14:12];
    ldop = (inst[6:0] == 7'h03);
    stop = (inst[6:0] == 7'h23);
    v = tv(inst, pc, dat, rd2, gd, rd, rdat, dat, dat & ~32'd3, m_be(f3, dat), m_wdat(f3, rd2), 0);
    if ((ldop || stop) && !m_mis(f3, dat)) begin
      if (ldop) begin
        v.exp_dat   = m_ext(f3, dat, rdat);
        v.exp_stall = gd + rd;
      end else begin
        v.exp_stall = gd;
      end
    end
    return v;
  endfunction

  // Drive one instruction and follow it to writeback, checking every cycle
  task automatic run_txn(input vec_t v);
    logic [2:0] f3;
    bit ldop, stop, mis;
    int stalls;
    f3     = v.inst[14:12];
    ldop   = (v.inst[6:0] == 7'h03);
    stop   = (v.inst[6:0] == 7'h23);
    mis    = (ldop || stop) && m_mis(f3, v.dat);
    stalls = 0;
    ma_inst = v.inst; ma_pc = v.pc; ma_dat = v.dat; ma_rd2 = v.rd2;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

    if (!(ldop || stop) || mis) begin
      dmem_gnt = 1'($urandom_range(0, 1));
      dmem_rvalid = 1'($urandom_range(0, 1));
      #1;
      chk("idle_req", 32'(dmem_req), 32'd0);
      chk("idle_stall", 32'(ma_stall), 32'd0);
      @(posedge clk); #1;
      chk("pass_inst", wb_inst, mis ? BUBBLE : v.inst);
      chk("pass_pc", wb_pc, v.pc);
      chk("pass_dat", wb_dat, v.exp_dat);
      chk("pass_misalign", 32'(wb_misalign), 32'(mis));
      return;
    end

    for (int c = 0; c <= v.gnt_dly; c++) begin
      dmem_gnt    = (c == v.gnt_dly);
      dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_rdat   = $urandom;
      if (c > 0) begin
        ma_inst = $urandom; ma_pc = $urandom; ma_dat = $urandom; ma_rd2 = $urandom;
      end
      #1;
      chk("req_req", 32'(dmem_req), 32'd1);
      chk("req_we", 32'(dmem_we), 32'(stop));
      chk("req_addr", dmem_addr, v.exp_addr);
      if (stop) begin
        chk("req_be", 32'(dmem_be), 32'(v.exp_be));
        chk("req_wdat", dmem_wdat, v.exp_wdat);
      end
      chk("req_stall", 32'(ma_stall), 32'(!(stop && c == v.gnt_dly)));
      if (ma_stall) stalls++;
      @(posedge clk); #1;
      if (!(stop && c == v.gnt_dly)) chk("req_bubble", wb_inst, BUBBLE);
    end

    if (ldop) begin
      for (int k = 1; k <= v.rv_dly; k++) begin
        dmem_gnt    = 1'($urandom_range(0, 1));
        dmem_rvalid = (k == v.rv_dly);
        dmem_rdat   = (k == v.rv_dly) ? v.rdat : $urandom;
        #1;
        chk("wait_req", 32'(dmem_req), 32'd0);
        chk("wait_stall", 32'(ma_stall), 32'(k != v.rv_dly));
        if (ma_stall) stalls++;
        @(posedge clk); #1;
        if (k != v.rv_dly) chk("wait_bubble", wb_inst, BUBBLE);
      end
      chk("ld_dat", wb_dat, v.exp_dat);
    end

    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("mem_inst", wb_inst, v.inst);
    chk("mem_pc", wb_pc, v.pc);
    chk("mem_misalign", 32'(wb_misalign), 32'd0);
    chk("stall_cycles", 32'(stalls), 32'(v.exp_stall));
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = tv(32'h0550_0093, 32'h100, 32'h55, 32'h0, 0, 0, 32'h0, 32'h55, 32'h54, 4'h0, 32'h0, 0);
    tbl[1] = tv(st(3'd0), 32'h104, 32'h1003, 32'hAB, 0, 0, 32'h0, 32'h0, 32'h1000, 4'b1000, 32'hABAB_ABAB, 0);
    tbl[2] = tv(ld(3'd0), 32'h108, 32'h2001, 32'h0, 2, 3, 32'h0000_8000, 32'hFFFF_FF80, 32'h2000, 4'h0, 32'h0, 5);
    tbl[3] = tv(ld(3'd5), 32'h10C, 32'h2002, 32'h0, 0, 1, 32'h8001_FFFF, 32'h0000_8001, 32'h2000, 4'h0, 32'h0, 1);
    tbl[4] = tv(ld(3'd1), 32'h110, 32'h2002, 32'h0, 1, 2, 32'h8001_FFFF, 32'hFFFF_8001, 32'h2000, 4'h0, 32'h0, 3);
    tbl[5] = tv(st(3'd2), 32'h114, 32'h4000, 32'hDEAD_BEEF, 4, 0, 32'h0, 32'h0, 32'h4000, 4'hF, 32'hDEAD_BEEF, 4);
    tbl[6] = tv(st(3'd1), 32'h118, 32'h1006, 32'h1234_ABCD, 1, 0, 32'h0, 32'h0, 32'h1004, 4'b1100, 32'hABCD_ABCD, 1);
`ifdef ETCPU_MA_MISALIGN_TRAP_EN
    tbl[7] = tv(ld(3'd2), 32'h11C, 32'h3002, 32'h0, 0, 2, 32'h1122_3344, 32'h3002, 32'h3000, 4'h0, 32'h0, 0);
`else
    tbl[7] = tv(ld(3'd2), 32'h11C, 32'h3002, 32'h0, 0, 2, 32'h1122_3344, 32'h1122_3344, 32'h3000, 4'h0, 32'h0, 2);
`endif
    tbl[8] = tv(ld(3'd4), 32'h120, 32'h5003, 32'h0, 1, 1, 32'h80FF_0000, 32'h0000_0080, 32'h5000, 4'h0, 32'h0, 2);
    tbl[9] = tv(ld(3'd6), 32'h124, 32'h6000, 32'h0, 0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h6000, 4'h0, 32'h0, 1);

    rst_n = 1'b0;
    ma_inst = BUBBLE; ma_pc = '0; ma_dat = '0; ma_rd2 = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdat = '0;
    #12;
    chk("rst_wb_inst", wb_inst, BUBBLE);
    chk("rst_wb_pc", wb_pc, 32'd0);
    chk("rst_wb_dat", wb_dat, 32'd0);
    chk("rst_misalign", 32'(wb_misalign), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Reset while a load waits for rvalid; the late rvalid must not write back
    ma_inst = ld(3'd2); ma_pc = 32'h200; ma_dat = 32'h7000; dmem_gnt = 1'b1;
    #1;
    @(posedge clk); #1;
    chk("rstmid_stall_before", 32'(ma_stall), 32'd1);
    dmem_gnt = 1'b0;
    ma_inst = BUBBLE; ma_pc = '0; ma_dat = '0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_req", 32'(dmem_req), 32'd0);
    chk("rstmid_stall", 32'(ma_stall), 32'd0);
    chk("rstmid_wb_inst", wb_inst, BUBBLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdat = 32'hFFFF_FFFF;
    #1;
    chk("late_rv_req", 32'(dmem_req), 32'd0);
    chk("late_rv_stall", 32'(ma_stall), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("late_rv_inst", wb_inst, BUBBLE);
    chk("late_rv_dat", wb_dat, 32'd0);
    chk("late_rv_pc", wb_pc, 32'd0);

    // Randomized traffic against the transaction model
    for (int i = 0; i < 80; i++) begin
      logic [31:0] inst, r;
      int kind;
      kind = $urandom_range(0, 2);
      r = $urandom;
      if (kind == 0)      inst = {r[31:15], r[14:12], r[11:7], ($urandom_range(0, 1) != 0) ? 7'h13 : 7'h33};
      else if (kind == 1) inst = {r[31:15], 3'($urandom_range(0, 7)), r[11:7], 7'h03};
      else                inst = {r[31:15], 3'($urandom_range(0, 2)), r[11:7], 7'h23};
      run_txn(model_vec(inst, $urandom, $urandom & 32'hFFFF, $urandom,
                        $urandom_range(0, 3), $urandom_range(1, 3), $urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
